// File: rtl/mod_n_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_n_updown_counter
// Brief    : Modulo-N up/down counter with load, runtime modulus, one-shot
//            halt and combinational terminal count for cascading.
// Revision : 1.0  initial release
// ============================================================================
module mod_n_updown_counter #(
    parameter int WIDTH = 4,
    parameter int N     = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mod_wr,
    input  logic [WIDTH-1:0] mod_in,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    localparam logic [0:0]       c_ST_RUN  = 1'b0;
    localparam logic [0:0]       c_ST_HALT = 1'b1;
    localparam logic [WIDTH-1:0] c_MAX_RST = WIDTH'(N - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] w_max_next;
    logic             r_wrap;
    logic             w_wrap_next;

    // State register: count, terminal value, FSM state and wrap pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_RUN;
            r_q     <= '0;
            r_max   <= c_MAX_RST;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_q     <= w_q_next;
            r_max   <= w_max_next;
            r_wrap  <= w_wrap_next;
        end
    end

    // Next-state logic. Counting compares against the current terminal value;
    // a load clamps against the terminal value that takes effect this edge.
    always_comb begin
        w_max_next   = (mod_wr && (mod_in != '0)) ? mod_in : r_max;
        w_state_next = r_state;
        w_q_next     = r_q;
        w_wrap_next  = 1'b0;

        if (load) begin
            w_q_next     = (load_val < w_max_next) ? load_val : w_max_next;
            w_state_next = c_ST_RUN;
        end else if ((r_state == c_ST_RUN) && en) begin
            if (up_dn) begin
                if (r_q >= r_max) begin
                    w_q_next    = '0;
                    w_wrap_next = 1'b1;
                end else begin
                    w_q_next = r_q + 1'b1;
                end
            end else begin
                if ((r_q == '0) || (r_q > r_max)) begin
                    w_q_next    = r_max;
                    w_wrap_next = 1'b1;
                end else begin
                    w_q_next = r_q - 1'b1;
                end
            end
            if (w_wrap_next && oneshot) begin
                w_state_next = c_ST_HALT;
            end
        end
    end

    // Output logic
    always_comb begin
        done = (r_state == c_ST_HALT);
        tc   = en && (r_state == c_ST_RUN) && !load &&
               (up_dn ? (r_q >= r_max) : (r_q == '0));
    end

    assign q    = r_q;
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_mod_n_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_n_updown_counter
// Brief    : Scoreboard bench for mod_n_updown_counter plus a two-stage cascade.
// Revision : 1.0  initial release
// ============================================================================
module tb_mod_n_updown_counter;

    localparam int WIDTH = 4;
    localparam int N     = 10;

    typedef struct {
        int q;
        bit wrap;
        bit done;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset, en, up_dn, oneshot, load, mod_wr;
    logic [WIDTH-1:0] load_val, mod_in;
    logic [WIDTH-1:0] q;
    logic             tc, wrap, done;

    // cascade signals
    logic             c_reset, c_en;
    logic             tie0, tie1;
    logic [WIDTH-1:0] tie_v;
    logic [WIDTH-1:0] s1_q, s2_q;
    logic             s1_tc, s2_tc, s1_wrap, s2_wrap, s1_done, s2_done;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    bit   tc_q[$];

    // reference model state
    int m_q    = 0;
    int m_max  = N - 1;
    bit m_halt = 0;
    bit m_wrap = 0;

    always #5 clk = ~clk;

    mod_n_updown_counter #(.WIDTH(WIDTH), .N(N)) dut (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .oneshot(oneshot),
        .load(load), .load_val(load_val), .mod_wr(mod_wr), .mod_in(mod_in),
        .q(q), .tc(tc), .wrap(wrap), .done(done)
    );

    mod_n_updown_counter #(.WIDTH(WIDTH), .N(N)) u_s1 (
        .clk(clk), .reset(c_reset), .en(c_en), .up_dn(tie1), .oneshot(tie0),
        .load(tie0), .load_val(tie_v), .mod_wr(tie0), .mod_in(tie_v),
        .q(s1_q), .tc(s1_tc), .wrap(s1_wrap), .done(s1_done)
    );

    mod_n_updown_counter #(.WIDTH(WIDTH), .N(N)) u_s2 (
        .clk(clk), .reset(c_reset), .en(s1_tc), .up_dn(tie1), .oneshot(tie0),
        .load(tie0), .load_val(tie_v), .mod_wr(tie0), .mod_in(tie_v),
        .q(s2_q), .tc(s2_tc), .wrap(s2_wrap), .done(s2_done)
    );

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    // Apply one cycle of stimulus and push the model's expectations.
    task automatic drive(input bit rs, input bit e, input bit u, input bit os,
                         input bit ld, input int lv, input bit mw, input int mi);
        int new_max;
        @(negedge clk);
        reset    = rs;
        en       = e;
        up_dn    = u;
        oneshot  = os;
        load     = ld;
        load_val = lv[WIDTH-1:0];
        mod_wr   = mw;
        mod_in   = mi[WIDTH-1:0];

        tc_q.push_back(e && !m_halt && !ld && (u ? (m_q >= m_max) : (m_q == 0)));

        m_wrap = 0;
        if (rs) begin
            m_q    = 0;
            m_max  = N - 1;
            m_halt = 0;
        end else begin
            new_max = (mw && mi != 0) ? mi : m_max;
            if (ld) begin
                m_q    = (lv < new_max) ? lv : new_max;
                m_halt = 0;
            end else if (e && !m_halt) begin
                if (u) begin
                    if (m_q + 1 > m_max) begin m_q = 0; m_wrap = 1; end
                    else m_q = m_q + 1;
                end else begin
                    if (m_q == 0 || m_q > m_max) begin m_q = m_max; m_wrap = 1; end
                    else m_q = m_q - 1;
                end
                if (m_wrap && os) m_halt = 1;
            end
            m_max = new_max;
        end
        exp_q.push_back('{q: m_q, wrap: m_wrap, done: m_halt});
    endtask

    // Monitor: combinational tc after inputs settle, registered outputs after the edge.
    always @(negedge clk) begin
        #2;
        if (tc_q.size() > 0) check("tc", int'(tc), int'(tc_q.pop_front()));
    end

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("q", int'(q), x.q);
            check("wrap", int'(wrap), int'(x.wrap));
            check("done", int'(done), int'(x.done));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit u_dir;
        reset = 0; en = 0; up_dn = 1; oneshot = 0; load = 0; mod_wr = 0;
        load_val = '0; mod_in = '0;
        c_reset = 1; c_en = 0; tie0 = 0; tie1 = 1; tie_v = '0;

        // free-running up from reset, then load clamp and load priority
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        repeat (11) drive(0, 1, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 12, 0, 0);
        drive(0, 1, 1, 0, 1, 3, 0, 0);
        repeat (5) drive(0, 1, 1, 0, 0, 0, 0, 0);
        // shrink modulus while q is high, then illegal zero modulus write
        drive(0, 1, 1, 0, 0, 0, 1, 5);
        repeat (8) drive(0, 1, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 1, 0);
        repeat (7) drive(0, 1, 1, 0, 0, 0, 0, 0);
        // one-shot from 7 with N restored by reset
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 7, 0, 0);
        repeat (5) drive(0, 1, 1, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 1, 2, 0, 0);
        // down-count through wrap, load with simultaneous modulus write
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (12) drive(0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 15, 1, 12);
        repeat (3) drive(0, 1, 0, 0, 0, 0, 0, 0);

        // randomized traffic
        u_dir = 1;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 15) == 0) u_dir = ~u_dir;
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0, u_dir,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0,
                  int'($urandom_range(0, 15)), $urandom_range(0, 13) == 0,
                  int'($urandom_range(0, 15)));
        end
        @(negedge clk);
        en = 0; load = 0; mod_wr = 0; reset = 0;
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);

        // cascade: stage2 counts tens of stage1
        @(negedge clk);
        c_reset = 1; c_en = 1;
        @(negedge clk);
        c_reset = 0;
        for (int k = 1; k <= 123; k++) begin
            @(posedge clk);
            #1;
            check("s1_q", int'(s1_q), k % 10);
            check("s2_q", int'(s2_q), (k / 10) % 10);
            check("s2_wrap", int'(s2_wrap), int'(k % 100 == 0));
        end
        @(negedge clk);
        c_reset = 1;
        @(posedge clk);
        #1;
        check("s1_q_reset", int'(s1_q), 0);
        check("s2_q_reset", int'(s2_q), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
